// File: rtl/tsmf_route_pp.sv
// Transport-stream packet router. A packet (tag word plus PKT_W words) is
// checked against a route table, then written out as a header word followed
// by the payload with a fixed two-cycle latency, into the lowest free bank.
// Rejected packets are counted; truncated packets abort with an error pulse.
module tsmf_route_pp #(
  parameter int  NCH   = 4,
  parameter int  PKT_W = 47,
  parameter int  NBANK = 2,
  localparam int BW    = $clog2(NBANK)
) (
  input  logic             clk_ts,
  input  logic             rst_ts_n,
  input  logic [31:0]      ts_din,
  input  logic             ts_din_en,
  input  logic [7:0]       cfg_din,
  input  logic             cfg_din_en,
  input  logic [NBANK-1:0] ram_full,
  output logic             ts_ram_wr,
  output logic [31:0]      ts_ram_wdata,
  output logic [BW-1:0]    ts_ram_bank,
  output logic             pkt_err,
  output logic [15:0]      drop_cnt
);

  typedef enum logic [1:0] {IDLE, CHECK, DATA, SKIP} state_t;
  typedef struct packed {
    logic       en;
    logic [3:0] ch;
  } route_t;

  localparam int            CW       = $clog2(PKT_W + 2);
  localparam logic [4:0]    NCH_L    = 5'(NCH);
  localparam logic [CW-1:0] LAST_IDX = CW'(PKT_W);
  localparam bit            ONE_WORD = (PKT_W == 1);

  state_t        r_state, w_next_state;
  route_t        r_stage  [15];
  route_t        r_shadow [16];
  route_t        r_active [16];
  logic          r_shadow_vld;
  logic [4:0]    r_cfg_cnt;
  logic [7:0]    r_seq    [16];
  logic [3:0]    r_tag_s;
  logic [31:0]   r_din_d;
  logic          r_en_d;
  logic [CW-1:0] r_cnt;
  logic          r_flush;
  logic [3:0]    r_ch;
  logic [BW-1:0] r_bank;
  logic          r_wr;
  logic [31:0]   r_wdata;
  logic          r_pkt_err;
  logic [15:0]   r_drop_cnt;

  route_t        w_cfg_route, w_route;
  logic          w_accept, w_last;
  logic [BW-1:0] w_free_bank;
  logic [31:0]   w_header;
  logic          w_tag_ld, w_hdr_ld, w_drop, w_trunc, w_data_ld, w_flush_set, w_wr_gate;
  logic          w_unused_cfg;

  // Route bits 6:4 are reserved and carry no meaning.
  assign w_unused_cfg = ^cfg_din[6:4];
  assign w_cfg_route  = route_t'({cfg_din[7], cfg_din[3:0]});
  assign w_route      = r_active[r_tag_s];
  assign w_accept     = (ts_din[31:24] == 8'h47) && w_route.en &&
                        ({1'b0, w_route.ch} < NCH_L) && !(&ram_full);
  assign w_last       = (r_cnt == LAST_IDX);
  assign w_header     = {8'hA5, 4'h0, w_route.ch, 8'h00, r_seq[w_route.ch]};

  // Lowest-index bank that can take a packet.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    w_free_bank = '0;
    for (int b = NBANK - 1; b >= 0; b--) begin
      if (!ram_full[b]) w_free_bank = BW'(b);
    end
  end

  // FSM state register.
  always_ff @(posedge clk_ts or negedge rst_ts_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_ts_n) r_state <= IDLE;
    else           r_state <= w_next_state;
  end

  // FSM next-state logic; a tag is only taken on a rising edge of ts_din_en.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:  if (ts_din_en && !r_en_d) w_next_state = CHECK;
      CHECK: if (!ts_din_en)           w_next_state = IDLE;
             else if (!w_accept)       w_next_state = SKIP;
             else                      w_next_state = ONE_WORD ? SKIP : DATA;
      DATA:  if (!ts_din_en)           w_next_state = IDLE;
             else if (w_last)          w_next_state = SKIP;
      SKIP:  if (!ts_din_en)           w_next_state = IDLE;
      default:                         w_next_state = IDLE;
    endcase
  end

  // FSM output decode driving the datapath.
  always_comb begin
    w_tag_ld    = (r_state == IDLE) && ts_din_en && !r_en_d;
    w_hdr_ld    = (r_state == CHECK) && ts_din_en && w_accept;
    w_drop      = (r_state == CHECK) && ts_din_en && !w_accept;
    w_trunc     = ((r_state == CHECK) || (r_state == DATA)) && !ts_din_en;
    w_data_ld   = (r_state == DATA) && ts_din_en;
    w_flush_set = (w_hdr_ld && ONE_WORD) || (w_data_ld && w_last);
    w_wr_gate   = (r_state == DATA) && !ts_din_en;
  end

  // Config capture: stage bytes 0..14, commit the full table on byte 15, and
  // promote shadow to active only between packets.
  always_ff @(posedge clk_ts or negedge rst_ts_n) begin
    if (!rst_ts_n) begin
      // NOTE: the route tables are small and their reset contents are visible
      // behaviour (all streams disabled), so they are reset like flops.
      for (int i = 0; i < 16; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
      for (int i = 0; i < 15; i++) r_stage[i] <= '0;
      r_shadow_vld <= 1'b0;
      r_cfg_cnt    <= '0;
    end else begin
      if ((r_state == IDLE) && r_shadow_vld) begin
        r_active     <= r_shadow;
        r_shadow_vld <= 1'b0;
      end
      if (!cfg_din_en) begin
        r_cfg_cnt <= '0;
      end else if (r_cfg_cnt < 5'd16) begin
        r_cfg_cnt <= r_cfg_cnt + 5'd1;
        if (r_cfg_cnt == 5'd15) begin
          for (int i = 0; i < 15; i++) r_shadow[i] <= r_stage[i];
          r_shadow[15] <= w_cfg_route;
          r_shadow_vld <= 1'b1;
        end else begin
          r_stage[r_cfg_cnt[3:0]] <= w_cfg_route;
        end
      end
    end
  end

  // Packet datapath: tag capture, one-word delay line, write port, counters.
  always_ff @(posedge clk_ts or negedge rst_ts_n) begin
    if (!rst_ts_n) begin
      for (int i = 0; i < 16; i++) r_seq[i] <= '0;
      r_tag_s    <= '0;
      r_din_d    <= '0;
      r_en_d     <= 1'b1;  // forces a low cycle before the first tag
      r_cnt      <= '0;
      r_flush    <= 1'b0;
      r_ch       <= '0;
      r_bank     <= '0;
      r_wr       <= 1'b0;
      r_wdata    <= '0;
      r_pkt_err  <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_en_d    <= ts_din_en;
      r_din_d   <= ts_din;
      r_wr      <= w_hdr_ld || w_data_ld || r_flush;
      r_flush   <= w_flush_set;
      r_pkt_err <= w_trunc;
      if (w_tag_ld) r_tag_s <= ts_din[3:0];
      if (w_hdr_ld) begin
        r_wdata <= w_header;
        r_ch    <= w_route.ch;
        r_bank  <= w_free_bank;
        r_cnt   <= CW'(2);
      end else if (w_data_ld || r_flush) begin
        r_wdata <= r_din_d;
      end
      if (w_data_ld) r_cnt <= r_cnt + CW'(1);
      if (r_flush) r_seq[r_ch] <= r_seq[r_ch] + 8'd1;
      if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  // A write already registered for the cycle ts_din_en falls is withheld.
  assign ts_ram_wr    = r_wr && !w_wr_gate;
  assign ts_ram_wdata = r_wdata;
  assign ts_ram_bank  = r_bank;
  assign pkt_err      = r_pkt_err;
  assign drop_cnt     = r_drop_cnt;

endmodule

// File: tb/tb_tsmf_route_pp.sv
// Scoreboard bench for tsmf_route_pp: stimulus tasks predict every RAM write
// (data, bank, cycle) from a route/sequence model; a monitor compares writes.
module tb_tsmf_route_pp;
  localparam int NCH   = 4;
  localparam int PKT_W = 47;
  localparam int NBANK = 2;
  localparam int BW    = $clog2(NBANK);

  logic             clk_ts = 1'b0;
  logic             rst_ts_n;
  logic [31:0]      ts_din;
  logic             ts_din_en;
  logic [7:0]       cfg_din;
  logic             cfg_din_en;
  logic [NBANK-1:0] ram_full;
  logic             ts_ram_wr;
  logic [31:0]      ts_ram_wdata;
  logic [BW-1:0]    ts_ram_bank;
  logic             pkt_err;
  logic [15:0]      drop_cnt;

  tsmf_route_pp #(.NCH(NCH), .PKT_W(PKT_W), .NBANK(NBANK)) dut (
    .clk_ts(clk_ts), .rst_ts_n(rst_ts_n), .ts_din(ts_din), .ts_din_en(ts_din_en),
    .cfg_din(cfg_din), .cfg_din_en(cfg_din_en), .ram_full(ram_full),
    .ts_ram_wr(ts_ram_wr), .ts_ram_wdata(ts_ram_wdata), .ts_ram_bank(ts_ram_bank),
    .pkt_err(pkt_err), .drop_cnt(drop_cnt)
  );

  always #5 clk_ts = ~clk_ts;

  typedef struct {
    logic [31:0]   data;
    logic [BW-1:0] bank;
    int            cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0, failures = 0;
  int          cyc = 0;
  int          err_seen = 0;
  logic [7:0]  m_route[16], m_pend[16], m_seq[16];
  bit          m_pend_vld;
  int          m_drop, exp_err;
  logic [31:0] m_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(posedge clk_ts) cyc <= cyc + 1;

  // Monitor: every write must match the oldest predicted write.
  always @(negedge clk_ts) begin
    if (pkt_err) err_seen++;
    if (ts_ram_wr) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'(exp_q.size()), 64'd1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wr_data", 64'(ts_ram_wdata), 64'(e.data));
        check("wr_bank", 64'(ts_ram_bank), 64'(e.bank));
        check("wr_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk_ts);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_route[i] = 8'h00;
      m_seq[i]   = 8'h00;
    end
    m_pend_vld = 0;
    m_drop     = 0;
    m_last     = 32'h0;
  endtask

  // Drive n config bytes; bytes past 16 are random filler.
  task automatic send_cfg(input logic [7:0] b[16], input int n);
    logic [31:0] t;
    for (int i = 0; i < n; i++) begin
      tick();
      t          = $urandom;
      cfg_din_en = 1'b1;
      cfg_din    = (i < 16) ? b[i] : t[7:0];
    end
    tick();
    cfg_din_en = 1'b0;
    if (n >= 16) begin
      m_pend     = b;
      m_pend_vld = 1;
    end
  endtask

  // Send one burst of nw words for stream s; rst_at >= 0 pulses reset
  // during that word. Predicts writes, drops, errors and sequence numbers.
  task automatic send_pkt(input int s, input bit sync_ok, input int nw,
                          input logic [NBANK-1:0] full, input int gap, input int rst_at);
    logic [7:0]  r;
    logic [31:0] w, t, hdr;
    int          ch, bank;
    bit          acc, complete;
    if (m_pend_vld) begin
      m_route    = m_pend;
      m_pend_vld = 0;
    end
    r        = m_route[s];
    ch       = int'(r[3:0]);
    acc      = sync_ok && r[7] && (ch < NCH) && (full != '1);
    bank     = 0;
    for (int b = NBANK - 1; b >= 0; b--) if (!full[b]) bank = b;
    complete = (nw >= PKT_W + 1);
    hdr      = {8'hA5, 4'h0, r[3:0], 8'h00, m_seq[ch]};
    for (int k = 0; k < nw; k++) begin
      tick();
      w = $urandom;
      t = $urandom;
      if (k == 0) begin
        w[3:0]   = 4'(s);
        ram_full = full;
      end
      if (k == 1) w[31:24] = sync_ok ? 8'h47 : (8'h47 ^ {t[7:1], 1'b1});
      if (k == 2) ram_full = t[NBANK-1:0];
      ts_din_en = 1'b1;
      ts_din    = w;
      if (acc && (k <= PKT_W) && (complete || (k < nw - 2)) &&
          ((rst_at < 0) || (k < rst_at - 2))) begin
        exp_q.push_back('{data: (k == 0) ? hdr : w, bank: BW'(bank), cyc: cyc + 2});
        m_last = (k == 0) ? hdr : w;
      end
      if (k == rst_at) begin
        rst_ts_n = 1'b0;
        #2;
        rst_ts_n = 1'b1;
      end
    end
    tick();
    ts_din_en = 1'b0;
    if (rst_at >= 0)   model_reset();
    else if (!acc)     m_drop = (m_drop == 65535) ? m_drop : m_drop + 1;
    else if (complete) m_seq[ch] = m_seq[ch] + 8'd1;
    else               exp_err++;
    check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    repeat (gap) tick();
  endtask

  task automatic check_status();
    repeat (4) tick();
    check("pkt_err_pulses", 64'(err_seen), 64'(exp_err));
    check("drop_cnt_idle", 64'(drop_cnt), 64'(m_drop));
    check("wdata_hold", 64'(ts_ram_wdata), 64'(m_last));
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [7:0]  base[16], remap[16], rnd[16];
    logic [31:0] t;
    rst_ts_n   = 1'b0;
    ts_din     = '0;
    ts_din_en  = 1'b0;
    cfg_din    = '0;
    cfg_din_en = 1'b0;
    ram_full   = '0;
    model_reset();
    exp_err = 0;
    repeat (3) tick();
    check("rst_wr", 64'(ts_ram_wr), 64'd0);
    check("rst_wdata", 64'(ts_ram_wdata), 64'd0);
    check("rst_bank", 64'(ts_ram_bank), 64'd0);
    check("rst_pkt_err", 64'(pkt_err), 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    rst_ts_n = 1'b1;
    repeat (2) tick();

    // Before any config every stream is disabled.
    send_pkt(1, 1, PKT_W + 1, 2'b00, 1, -1);

    base    = '{default: 8'h00};
    base[0] = 8'h81; base[1] = 8'h82; base[2] = 8'h83;
    base[3] = 8'h03; base[5] = 8'h85; base[6] = 8'hF1;
    send_cfg(base, 18);                        // trailing bytes ignored

    send_pkt(1, 1, PKT_W + 1, 2'b00, 1, -1);   // header A5020000
    send_pkt(1, 1, PKT_W + 1, 2'b00, 0, -1);   // header A5020001
    send_pkt(1, 1, PKT_W + 1, 2'b01, 1, -1);   // bank 1
    send_pkt(1, 1, PKT_W + 1, 2'b11, 1, -1);   // all banks full: drop
    send_pkt(3, 1, PKT_W + 1, 2'b00, 1, -1);   // route disabled: drop
    send_pkt(1, 0, PKT_W + 1, 2'b00, 1, -1);   // bad sync: drop
    send_pkt(5, 1, PKT_W + 1, 2'b00, 1, -1);   // channel >= NCH: drop
    send_pkt(1, 1, 20, 2'b00, 1, -1);          // truncated: 18 writes
    send_pkt(1, 1, PKT_W + 1, 2'b00, 1, -1);   // seq unchanged by truncation
    send_pkt(6, 1, PKT_W + 4, 2'b10, 1, -1);   // overlong burst, bank 0
    check_status();

    remap    = base;
    remap[1] = 8'h80;
    send_cfg(remap, 10);                       // short burst discarded
    send_pkt(1, 1, PKT_W + 1, 2'b00, 1, -1);   // still channel 2
    fork
      send_pkt(1, 1, PKT_W + 1, 2'b00, 1, -1); // keeps channel 2
      begin
        repeat (5) tick();
        send_cfg(remap, 16);
      end
    join
    send_pkt(1, 1, PKT_W + 1, 2'b00, 0, -1);   // header A5000000
    for (int i = 0; i < 256; i++) send_pkt(1, 1, PKT_W + 1, 2'b00, 0, -1);
    send_pkt(1, 1, PKT_W + 1, 2'b00, 1, -1);   // seq back to 01 after wrap
    check_status();

    for (int p = 0; p < 40; p++) begin
      int nw, sel;
      t = $urandom;
      if (t[3:0] == 4'd0) begin
        for (int i = 0; i < 16; i++) begin
          logic [31:0] tb;
          tb     = $urandom;
          rnd[i] = tb[7:0];
        end
        send_cfg(rnd, 16);
      end
      sel = $urandom_range(0, 9);
      nw  = (sel < 7) ? PKT_W + 1 :
            (sel < 9) ? $urandom_range(2, PKT_W) : PKT_W + 1 + $urandom_range(1, 3);
      send_pkt($urandom_range(0, 7), ($urandom_range(0, 9) != 0), nw,
               NBANK'($urandom_range(0, 3)), $urandom_range(0, 2), -1);
    end
    check_status();

    send_pkt(1, 1, PKT_W + 1, 2'b00, 1, -1);
    send_pkt(1, 1, PKT_W + 1, 2'b00, 1, 12);   // reset mid-packet
    check("post_rst_drop", 64'(drop_cnt), 64'd0);
    send_cfg(base, 16);
    send_pkt(1, 1, PKT_W + 1, 2'b00, 1, -1);   // header A5020000 again
    check_status();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
